mem_access_seq: RTL

//  Sequences the single memory port of the multicycle CPU. Arbitrates memory requests from

---
 rtl/mem_access_seq_pkg.sv | 17 +
 rtl/mem_access_seq_if.sv | 23 ++
 rtl/mem_access_seq_arb.sv | 18 +
 rtl/mem_access_seq.sv | 74 +++++++
 4 files changed

// File: rtl/mem_access_seq_pkg.sv
// mem_seq_pkg: shared IorD codes, FSM states and requester ids for the memory sequencer
package mem_seq_pkg;
  localparam int CNT_W = 4;
  localparam logic [2:0] IORD_PC     = 3'd0;
  localparam logic [2:0] IORD_EXCP   = 3'd1;
  localparam logic [2:0] IORD_ALURES = 3'd2;
  localparam logic [2:0] IORD_ALUOUT = 3'd3;
  localparam logic [2:0] IORD_REGA   = 3'd4;
  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_DONE} state_t;
  typedef enum logic [1:0] {REQ_FETCH = 2'd0, REQ_EXCP = 2'd1, REQ_LDST = 2'd2} req_id_t;
  function automatic logic [2:0] iord_code(input logic [2:0] gnt, input logic [1:0] src);
    return gnt[REQ_EXCP] ? IORD_EXCP :
           !gnt[REQ_LDST] ? IORD_PC :
           src == 2'd1 ? IORD_REGA :
           src == 2'd2 ? IORD_ALURES : IORD_ALUOUT;
  endfunction
endpackage

// File: rtl/mem_access_seq_if.sv
// mem_access_seq_if: request/response bundle between control FSM and memory sequencer
interface mem_access_seq_if #(parameter int SEL_W = 3);
  logic             fetch_req;
  logic             excp_req;
  logic             ldst_req;
  logic             ldst_wr;
  logic [1:0]       ldst_src;
  logic [SEL_W-1:0] IorD;
  logic             MemWr;
  logic             rd_valid;
  logic             fetch_done;
  logic             excp_done;
  logic             ldst_done;
  logic             busy;
  modport master(
    output fetch_req, excp_req, ldst_req, ldst_wr, ldst_src,
    input  IorD, MemWr, rd_valid, fetch_done, excp_done, ldst_done, busy
  );
  modport slave(
    input  fetch_req, excp_req, ldst_req, ldst_wr, ldst_src,
    output IorD, MemWr, rd_valid, fetch_done, excp_done, ldst_done, busy
  );
endinterface

// File: rtl/mem_access_seq_arb.sv
// mem_prio_arb: fixed-priority (excp > ldst > fetch) one-hot arbiter with request mask
module mem_prio_arb
  import mem_seq_pkg::*;
(
  input  logic [2:0] req,
  input  logic [2:0] mask,
  output logic [2:0] gnt
);
  logic [2:0] r;
  assign r = req & ~mask;
  // highest-priority unmasked request wins
  always_comb begin
    gnt            = '0;
    gnt[REQ_EXCP]  = r[REQ_EXCP];
    gnt[REQ_LDST]  = r[REQ_LDST] & ~r[REQ_EXCP];
    gnt[REQ_FETCH] = r[REQ_FETCH] & ~r[REQ_EXCP] & ~r[REQ_LDST];
  end
endmodule

// File: rtl/mem_access_seq.sv
// mem_access_seq: arbitrates and sequences the single memory port of the multicycle CPU
module mem_access_seq
  import mem_seq_pkg::*;
#(
  parameter int MEM_LAT = 2,
  parameter int SEL_W   = 3
) (
  input logic              clk,
  input logic              reset_n,
  mem_access_seq_if.slave  bus
);
  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       req, mask, gnt, gnt_q, gnt_n;
  logic             wr_q, wr_n;
  logic [SEL_W-1:0] iord, iord_n;
  assign req  = {bus.ldst_req, bus.excp_req, bus.fetch_req};
  assign mask = state == S_DONE ? gnt_q : '0;
  mem_prio_arb u_arb (
    .req  (req),
    .mask (mask),
    .gnt  (gnt)
  );
  // state, wait counter and latched grant/IorD registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      gnt_q <= '0;
      wr_q  <= 1'b0;
      iord  <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      gnt_q <= gnt_n;
      wr_q  <= wr_n;
      iord  <= iord_n;
    end
  end
  // next state; grants are taken in IDLE and DONE so back-to-back accesses need no bubble
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    gnt_n   = gnt_q;
    wr_n    = wr_q;
    iord_n  = iord;
    case (state)
      S_IDLE, S_DONE: begin
        state_n = |gnt ? S_ACCESS : S_IDLE;
        if (|gnt) begin
          gnt_n  = gnt;
          wr_n   = gnt[REQ_LDST] & bus.ldst_wr;
          iord_n = SEL_W'(iord_code(gnt, bus.ldst_src));
        end
      end
      S_ACCESS: begin
        cnt_n   = CNT_W'(MEM_LAT - 1);
        state_n = (wr_q || MEM_LAT == 1) ? S_DONE : S_WAIT;
      end
      S_WAIT: begin
        cnt_n   = cnt - 1'b1;
        state_n = cnt_n == '0 ? S_DONE : S_WAIT;
      end
      default: state_n = S_IDLE;
    endcase
  end
  assign bus.IorD       = iord;
  assign bus.MemWr      = state == S_ACCESS && wr_q;
  assign bus.rd_valid   = state == S_DONE && !wr_q;
  assign bus.fetch_done = state == S_DONE && gnt_q[REQ_FETCH];
  assign bus.excp_done  = state == S_DONE && gnt_q[REQ_EXCP];
  assign bus.ldst_done  = state == S_DONE && gnt_q[REQ_LDST];
  assign bus.busy       = state != S_IDLE;
endmodule
